// File: rtl/ex_memreq_seq_if.sv
// L1 data-cache request port between ex_memreq_seq (master) and the cache (slave).
interface ex_memreq_seq_if;
  logic [31:0] memAddr;
  logic [4:0]  memOpm;
  logic [63:0] memDataOut;
  logic [63:0] memDataIn;
  logic [1:0]  memOK;

  modport master (
    output memAddr, memOpm, memDataOut,
    input  memDataIn, memOK
  );

  modport slave (
    input  memAddr, memOpm, memDataOut,
    output memDataIn, memOK
  );
endinterface

// File: rtl/ex_memreq_seq.sv
// EX1 -> L1 memory-request sequencer: latches one load/store, holds it across the
// cache handshake, extends load data for EX2 writeback. Optional JX2_MEMSEQ_TIMEOUT_EN.
module ex_memreq_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  exOpm,
  input  logic [31:0] exAddr,
  input  logic [63:0] exDataOut,
  input  logic [5:0]  exIdRn,
  input  logic        exFlush,
  output logic        exHold,
  output logic [5:0]  heldIdRn2,
  output logic [5:0]  regIdRn2,
  output logic [63:0] regValRn2,
  ex_memreq_seq_if.master memPort,
  input  logic        faultAck,
  output logic        memFault,
  output logic [31:0] faultAddr
);

  localparam logic [5:0] JX2_GR_ZZR = 6'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] MEM_READY = 2'd0;
  localparam logic [1:0] MEM_OK    = 2'd1;
  localparam logic [1:0] MEM_FAULT = 2'd3;

  localparam logic [4:0] OPM_READY = 5'b00000;

  logic [1:0]  state;
  logic        reqValid;
  logic        reqIsLoad;
  logic        reqTimeout;
  logic        loadSgn;
  logic [63:0] loadVal;

  assign exHold    = (state != ST_IDLE);
  assign reqIsLoad = (exOpm[4:3] == 2'b01);
  assign reqValid  = (reqIsLoad || (exOpm[4:3] == 2'b10)) && !exFlush;
  assign loadSgn   = ~memPort.memOpm[2];

  always_comb begin
    loadVal = memPort.memDataIn;
    case (memPort.memOpm[1:0])
      2'b00:   loadVal = {{56{loadSgn & memPort.memDataIn[7]}},  memPort.memDataIn[7:0]};
      2'b01:   loadVal = {{48{loadSgn & memPort.memDataIn[15]}}, memPort.memDataIn[15:0]};
      2'b10:   loadVal = {{32{loadSgn & memPort.memDataIn[31]}}, memPort.memDataIn[31:0]};
      default: loadVal = memPort.memDataIn;
    endcase
  end

`ifdef JX2_MEMSEQ_TIMEOUT_EN
  logic [7:0] toCnt;

  // Counter is only ever nonzero in REQ, so clearing in IDLE equals clearing on REQ entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      toCnt <= '0;
    end else if (state != ST_REQ) begin
      toCnt <= '0;
    end else if ((memPort.memOK != MEM_OK) && (toCnt != 8'hFF)) begin
      toCnt <= toCnt + 8'd1;
    end
  end

  // Fault on the REQ cycle in which the count advances to 255.
  assign reqTimeout = (state == ST_REQ) && (toCnt == 8'hFE);
`else
  assign reqTimeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      memPort.memAddr    <= '0;
      memPort.memOpm     <= OPM_READY;
      memPort.memDataOut <= '0;
      heldIdRn2          <= JX2_GR_ZZR;
      regIdRn2           <= JX2_GR_ZZR;
      regValRn2          <= '0;
      memFault           <= 1'b0;
      faultAddr          <= '0;
    end else begin
      regIdRn2 <= JX2_GR_ZZR;
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            state              <= ST_REQ;
            memPort.memAddr    <= exAddr;
            memPort.memOpm     <= exOpm;
            memPort.memDataOut <= exDataOut;
            heldIdRn2          <= reqIsLoad ? exIdRn : JX2_GR_ZZR;
          end
        end
        ST_REQ: begin
          if (memPort.memOK == MEM_OK) begin
            state          <= ST_DONE;
            memPort.memOpm <= OPM_READY;
            if (memPort.memOpm[4:3] == 2'b01) begin
              regIdRn2  <= heldIdRn2;
              regValRn2 <= loadVal;
            end
          end else if ((memPort.memOK == MEM_FAULT) || reqTimeout) begin
            state          <= ST_FAULT;
            memPort.memOpm <= OPM_READY;
            memFault       <= 1'b1;
            faultAddr      <= memPort.memAddr;
          end
        end
        ST_DONE: begin
          if (memPort.memOK == MEM_READY) begin
            state     <= ST_IDLE;
            heldIdRn2 <= JX2_GR_ZZR;
          end
        end
        default: begin
          if (faultAck && (memPort.memOK == MEM_READY)) begin
            state     <= ST_IDLE;
            memFault  <= 1'b0;
            heldIdRn2 <= JX2_GR_ZZR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_memreq_seq.sv
// Directed self-checking bench for ex_memreq_seq: loads, store, fault, flush, reset, back-to-back.
module tb_ex_memreq_seq;

  localparam logic [5:0] ZZR = 6'h3F;
  localparam logic [1:0] OK_READY = 2'd0;
  localparam logic [1:0] OK_OK    = 2'd1;
  localparam logic [1:0] OK_HOLD  = 2'd2;
  localparam logic [1:0] OK_FAULT = 2'd3;

  logic        clock;
  logic        reset;
  logic [4:0]  exOpm;
  logic [31:0] exAddr;
  logic [63:0] exDataOut;
  logic [5:0]  exIdRn;
  logic        exFlush;
  logic        exHold;
  logic [5:0]  heldIdRn2;
  logic [5:0]  regIdRn2;
  logic [63:0] regValRn2;
  logic        faultAck;
  logic        memFault;
  logic [31:0] faultAddr;

  int nAsserts = 0;
  int nFails   = 0;
  int holdCnt  = 0;

  ex_memreq_seq_if memIf ();

  ex_memreq_seq dut (
    .clock     (clock),
    .reset     (reset),
    .exOpm     (exOpm),
    .exAddr    (exAddr),
    .exDataOut (exDataOut),
    .exIdRn    (exIdRn),
    .exFlush   (exFlush),
    .exHold    (exHold),
    .heldIdRn2 (heldIdRn2),
    .regIdRn2  (regIdRn2),
    .regValRn2 (regValRn2),
    .memPort   (memIf),
    .faultAck  (faultAck),
    .memFault  (memFault),
    .faultAddr (faultAddr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nAsserts++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply memOK for the current cycle, advance one clock, count stalled cycles.
  task automatic cyc(input logic [1:0] ok);
    memIf.memOK = ok;
    tick();
    if (exHold) holdCnt++;
  endtask

  task automatic issue(input logic [4:0] opm, input logic [31:0] addr,
                       input logic [63:0] data, input logic [5:0] id);
    exOpm = opm; exAddr = addr; exDataOut = data; exIdRn = id;
    cyc(OK_READY);
    exOpm = 5'b0; exAddr = 32'hFFFF_FFFF; exDataOut = 64'hBAD0_BAD0_BAD0_BAD0; exIdRn = 6'd0;
  endtask

  initial begin
    reset = 1'b1; exOpm = '0; exAddr = '0; exDataOut = '0; exIdRn = '0;
    exFlush = 1'b0; faultAck = 1'b0; memIf.memOK = OK_READY; memIf.memDataIn = '0;
    #2 reset = 1'b0;
    tick(); tick();
    checkVal("rst_memOpm",   64'(memIf.memOpm), 64'd0);
    checkVal("rst_memAddr",  64'(memIf.memAddr), 64'd0);
    checkVal("rst_exHold",   64'(exHold), 64'd0);
    checkVal("rst_regIdRn2", 64'(regIdRn2), 64'(ZZR));
    checkVal("rst_heldId",   64'(heldIdRn2), 64'(ZZR));
    checkVal("rst_memFault", 64'(memFault), 64'd0);
    #3 reset = 1'b1;
    tick();

    // Signed byte load with 1 READY + 3 HOLD cycles before OK
    holdCnt = 0;
    issue(5'b01000, 32'h0000_1000, 64'd0, 6'd5);
    checkVal("sb_memOpm",  64'(memIf.memOpm), 64'h08);
    checkVal("sb_memAddr", 64'(memIf.memAddr), 64'h1000);
    checkVal("sb_heldId",  64'(heldIdRn2), 64'd5);
    cyc(OK_READY);
    cyc(OK_HOLD); cyc(OK_HOLD); cyc(OK_HOLD);
    checkVal("sb_noWbYet", 64'(regIdRn2), 64'(ZZR));
    memIf.memDataIn = 64'h80;
    cyc(OK_OK);
    checkVal("sb_regId",  64'(regIdRn2), 64'd5);
    checkVal("sb_regVal", regValRn2, 64'hFFFF_FFFF_FFFF_FF80);
    checkVal("sb_opmRdy", 64'(memIf.memOpm), 64'd0);
    cyc(OK_READY);
    checkVal("sb_holdCnt", 64'(holdCnt), 64'd6);
    checkVal("sb_exHoldLo", 64'(exHold), 64'd0);
    checkVal("sb_heldZzr", 64'(heldIdRn2), 64'(ZZR));
    checkVal("sb_regIdZzr", 64'(regIdRn2), 64'(ZZR));

    // Unsigned word load; DONE held by HOLD shows writeback lasts one cycle
    issue(5'b01101, 32'h0000_2002, 64'd0, 6'd7);
    memIf.memDataIn = 64'hFFFF_8001;
    cyc(OK_OK);
    checkVal("uw_regId",  64'(regIdRn2), 64'd7);
    checkVal("uw_regVal", regValRn2, 64'h0000_0000_0000_8001);
    cyc(OK_HOLD);
    checkVal("uw_regId1cyc", 64'(regIdRn2), 64'(ZZR));
    checkVal("uw_doneHold",  64'(exHold), 64'd1);
    cyc(OK_READY);
    checkVal("uw_idle", 64'(exHold), 64'd0);

    // Signed long and quad pass-through
    issue(5'b01010, 32'h0000_3000, 64'd0, 6'd8);
    memIf.memDataIn = 64'h1234_5678_8000_0001;
    cyc(OK_OK);
    checkVal("sl_regVal", regValRn2, 64'hFFFF_FFFF_8000_0001);
    cyc(OK_READY);
    issue(5'b01011, 32'h0000_3008, 64'd0, 6'd9);
    memIf.memDataIn = 64'hFEDC_BA98_7654_3210;
    cyc(OK_OK);
    checkVal("q_regVal", regValRn2, 64'hFEDC_BA98_7654_3210);
    cyc(OK_READY);

    // Quad store: request regs stable while inputs change, no writeback
    issue(5'b10011, 32'h0000_4000, 64'h0123_4567_89AB_CDEF, 6'd10);
    checkVal("st_memOpm", 64'(memIf.memOpm), 64'h13);
    cyc(OK_HOLD); cyc(OK_HOLD);
    checkVal("st_dataStable", memIf.memDataOut, 64'h0123_4567_89AB_CDEF);
    checkVal("st_addrStable", 64'(memIf.memAddr), 64'h4000);
    checkVal("st_opmStable",  64'(memIf.memOpm), 64'h13);
    cyc(OK_OK);
    checkVal("st_noWb", 64'(regIdRn2), 64'(ZZR));
    cyc(OK_READY);

    // Fault, ack blocked while memOK != READY, then cleared
    issue(5'b01000, 32'hDEAD_0000, 64'd0, 6'd11);
    cyc(OK_FAULT);
    checkVal("f_memFault",  64'(memFault), 64'd1);
    checkVal("f_faultAddr", 64'(faultAddr), 64'hDEAD_0000);
    checkVal("f_exHold",    64'(exHold), 64'd1);
    checkVal("f_opmRdy",    64'(memIf.memOpm), 64'd0);
    checkVal("f_noWb",      64'(regIdRn2), 64'(ZZR));
    faultAck = 1'b1;
    cyc(OK_HOLD);
    checkVal("f_ackBlocked", 64'(memFault), 64'd1);
    cyc(OK_READY);
    checkVal("f_cleared", 64'(memFault), 64'd0);
    checkVal("f_idle",    64'(exHold), 64'd0);
    cyc(OK_READY);
    checkVal("f_ackIdle", 64'(exHold), 64'd0);
    faultAck = 1'b0;

    // Flush drops a valid request; reserved opcode ignored
    exFlush = 1'b1;
    issue(5'b01000, 32'h0000_5000, 64'd0, 6'd12);
    exFlush = 1'b0;
    checkVal("fl_memOpm", 64'(memIf.memOpm), 64'd0);
    checkVal("fl_exHold", 64'(exHold), 64'd0);
    issue(5'b11000, 32'h0000_5000, 64'd0, 6'd12);
    checkVal("rsv_exHold", 64'(exHold), 64'd0);

    // Async reset mid-REQ
    issue(5'b01000, 32'h0000_6000, 64'd0, 6'd6);
    cyc(OK_HOLD);
    reset = 1'b0;
    #1;
    checkVal("mr_memOpm", 64'(memIf.memOpm), 64'd0);
    checkVal("mr_exHold", 64'(exHold), 64'd0);
    checkVal("mr_heldId", 64'(heldIdRn2), 64'(ZZR));
    reset = 1'b1;
    memIf.memDataIn = 64'h55;
    cyc(OK_OK);
    checkVal("mr_noWb",  64'(regIdRn2), 64'(ZZR));
    checkVal("mr_idle",  64'(exHold), 64'd0);
    cyc(OK_READY);

    // Back-to-back loads, second accepted in first IDLE cycle
    issue(5'b01000, 32'h0000_7000, 64'd0, 6'd3);
    checkVal("bb_held3", 64'(heldIdRn2), 64'd3);
    memIf.memDataIn = 64'h11;
    cyc(OK_OK);
    checkVal("bb_regId3",  64'(regIdRn2), 64'd3);
    checkVal("bb_regVal3", regValRn2, 64'h11);
    exOpm = 5'b01000; exAddr = 32'h0000_7001; exIdRn = 6'd4;
    cyc(OK_READY);
    checkVal("bb_gapZzr", 64'(heldIdRn2), 64'(ZZR));
    issue(5'b01000, 32'h0000_7001, 64'd0, 6'd4);
    checkVal("bb_held4", 64'(heldIdRn2), 64'd4);
    checkVal("bb_addr4", 64'(memIf.memAddr), 64'h7001);
    memIf.memDataIn = 64'h22;
    cyc(OK_OK);
    checkVal("bb_regId4",  64'(regIdRn2), 64'd4);
    checkVal("bb_regVal4", regValRn2, 64'h22);
    cyc(OK_READY);
    checkVal("bb_heldEnd", 64'(heldIdRn2), 64'(ZZR));

    // Endless HOLD: timeout fault when enabled, otherwise REQ persists
    issue(5'b01000, 32'h0000_8000, 64'd0, 6'd13);
`ifdef JX2_MEMSEQ_TIMEOUT_EN
    begin
      int reqCycles = 0;
      while (!memFault && reqCycles < 300) begin
        cyc(OK_HOLD);
        reqCycles++;
      end
      checkVal("to_cycles",    64'(reqCycles), 64'd255);
      checkVal("to_faultAddr", 64'(faultAddr), 64'h8000);
      faultAck = 1'b1;
      cyc(OK_READY);
      faultAck = 1'b0;
    end
`else
    for (int i = 0; i < 1000; i++) cyc(OK_HOLD);
    checkVal("nto_exHold",   64'(exHold), 64'd1);
    checkVal("nto_memFault", 64'(memFault), 64'd0);
    checkVal("nto_memOpm",   64'(memIf.memOpm), 64'h08);
    cyc(OK_OK);
    cyc(OK_READY);
`endif
    checkVal("end_idle", 64'(exHold), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/ex_memreq_seq.md
# ex_memreq_seq

Memory-request sequencer between the EX1 stage and the L1 data-cache port. EX1 only initiates a load/store for one cycle; this block latches the request and holds it on the cache port across the OK/HOLD/FAULT handshake. It stalls the pipeline through exHold, sign/zero-extends load data and returns it as a one-cycle EX2 writeback. It also reports faults until software acknowledges them.

## Interface
Parameters:
- none. Widths are fixed by the core: 32-bit address, 64-bit data, 6-bit GPR ID.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- exOpm  in  5  EX1 request: [4:3] 00=READY, 01=load, 10=store, 11=reserved (ignored); [2]=unsigned; [1:0] size 00=B, 01=W, 10=L, 11=Q
- exAddr  in  32  EX1 effective address
- exDataOut  in  64  EX1 store data
- exIdRn  in  6  EX1 load destination (held ID)
- exFlush  in  1  branch flush; suppresses acceptance this cycle
- exHold  out  1  pipeline stall
- heldIdRn2  out  6  destination of in-flight load, else JX2_GR_ZZR
- regIdRn2  out  6  writeback ID, else JX2_GR_ZZR
- regValRn2  out  64  writeback value
- memAddr  out  32  cache address (registered)
- memOpm  out  5  cache opcode (registered)
- memDataOut  out  64  cache store data (registered)
- memDataIn  in  64  cache load data, right-aligned to bit 0
- memOK  in  2  cache status: 0=READY, 1=OK, 2=HOLD, 3=FAULT
- faultAck  in  1  clears the sticky fault
- memFault  out  1  sticky fault flag
- faultAddr  out  32  address of the faulting request

## Operation
States: IDLE, REQ, DONE, FAULT.

- **IDLE**
  - Accept when exOpm[4:3] is 01 or 10 and exFlush=0.
  - On accept, latch addr/opm/data/ID into memAddr/memOpm/memDataOut/heldIdRn2 and go to REQ.
  - Otherwise memOpm=READY. Reserved opcode 11 is treated as READY.
- **REQ**
  - Request regs stay stable; ex* inputs are ignored.
  - memOK=HOLD or READY: stay in REQ.
  - memOK=OK: go to DONE and set memOpm=READY. For a load, also register regIdRn2=heldIdRn2 and regValRn2=ext(memDataIn).
  - memOK=FAULT: go to FAULT, set memFault=1, set faultAddr=memAddr, set memOpm=READY. No writeback.
- **DONE**
  - regIdRn2 returns to ZZR after one cycle.
  - Wait for memOK=READY, then go to IDLE and set heldIdRn2=ZZR.
- **FAULT**
  - Wait for faultAck=1 and memOK=READY. Then go to IDLE and clear memFault.
- **Load extension ext()**
  - B/W/L: take the low 8/16/32 bits.
  - Replicate the top bit of that field when [2]=0; zero-fill when [2]=1.
  - Q: pass through.
- Stores produce no writeback. regValRn2 is don't-care while regIdRn2=ZZR.
- exHold = (state != IDLE). This is combinational from the state register.

## Timing
- Reset (async, low):
  - State IDLE; memOpm=READY; memAddr=0; memDataOut=0.
  - regIdRn2=heldIdRn2=ZZR; regValRn2=0.
  - memFault=0; faultAddr=0.
  - The effect is immediate, including mid-request: no writeback, no fault.
- Request seen by EX1 in cycle N:
  - memOpm is valid from N+1.
  - exHold is high from N+1.
- memOK=OK sampled in cycle M:
  - regIdRn2/regValRn2 are valid in M+1 only.
  - Earliest exHold low is M+2, when memOK=READY in M+1.
  - Minimum occupancy is 3 cycles (REQ, DONE, then IDLE).
- Back-to-back: a new request can be accepted in the first IDLE cycle.
- Simultaneous events:
  - exFlush together with a valid request in IDLE: the request is dropped.
  - faultAck together with memOK≠READY: remain in FAULT.
  - faultAck outside FAULT: ignored.

## Configuration
- JX2_MEMSEQ_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle with memOK≠OK.
  - When it reaches 255 in REQ, take the FAULT path with faultAddr=memAddr.
  - The counter saturates and never wraps.
- Undefined: no counter; REQ waits indefinitely.

## Test plan
- **Signed byte load:** exOpm=01_0_00, addr=0x1000, ID=5; memOK HOLD 3 cycles, then OK with memDataIn=0x80 → regIdRn2=5, regValRn2=0xFFFFFFFFFFFFFF80 for one cycle; exHold high for 6 cycles.
- **Unsigned word load:** exOpm=01_1_01, memDataIn=0xFFFF8001 → regValRn2=0x0000000000008001. Quad store exOpm=10_0_11, data=0x0123456789ABCDEF → memDataOut stable through the handshake; regIdRn2 stays ZZR.
- **Fault:** request at addr=0xDEAD0000, then memOK=FAULT → memFault=1, faultAddr=0xDEAD0000, exHold high. Holding faultAck=1 while memOK=READY → IDLE next edge, memFault=0.
- **Flush and reset:** exFlush=1 with a valid load → no memOpm change, exHold stays 0. Reset asserted mid-REQ → memOpm=READY and exHold=0 immediately; no writeback after release.
- **Timeout (macro on):** memOK held at HOLD → fault raised after 255 REQ cycles. With the macro off, the same stimulus stays in REQ for 1000 cycles.
- **Back-to-back:** two loads (IDs 3, 4) issued consecutively → two writebacks in order; heldIdRn2 tracks 3, then 4, then ZZR.
